// File: rtl/ex_stage_md.sv
// ex_stage_md -- execute stage of the five-stage pipeline.
//
// Purpose:
//   * XLEN-wide ALU with forwarding muxes on both operands.
//   * Full conditional-branch compare and the PC redirect (branch, JAL, JALR).
//   * Iterative unsigned multiply/divide unit (shift-add / restoring
//     division, one bit per cycle) that holds the front end while it runs.
//   * Owns the EX/MEM pipeline register. Downstream back-pressure holds it,
//     and bubbles are inserted while the multiply/divide unit is busy.
//
// Ports:
//   clk, reset_n               clock (rising edge), async active-low reset
//   ForwardAE/ForwardBE        operand source select (10 EX/MEM, 01 WB, else reg)
//   id_ex_*                    decoded instruction held in the ID/EX register
//   ex_mem_alu_result_in       forwarding source from EX/MEM
//   wb_data_in                 forwarding source from WB
//   mem_stall                  MEM cannot accept; EX/MEM holds
//   ex_busy                    hold IF, ID and ID/EX this cycle
//   PCSrc, PC_branch           combinational PC redirect and its target
//   ex_mem_*                   registered EX/MEM fields
module ex_stage_md #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic            id_ex_valid,
    input  logic [XLEN-1:0] id_ex_pc,
    input  logic [XLEN-1:0] id_ex_rs1_val,
    input  logic [XLEN-1:0] id_ex_rs2_val,
    input  logic [XLEN-1:0] id_ex_imm,
    input  logic [4:0]      id_ex_rd_idx,
    input  logic            id_ex_RegWrite,
    input  logic            id_ex_MemRead,
    input  logic            id_ex_MemWrite,
    input  logic            id_ex_ALUSrc,
    input  logic [1:0]      id_ex_ResultSrc,
    input  logic [3:0]      id_ex_ALUCtl,
    input  logic            id_ex_MulDiv,
    input  logic [1:0]      id_ex_MdOp,
    input  logic            id_ex_Branch,
    input  logic            id_ex_Jal,
    input  logic            id_ex_Jalr,
    input  logic [2:0]      id_ex_BrCond,
    input  logic [XLEN-1:0] ex_mem_alu_result_in,
    input  logic [XLEN-1:0] wb_data_in,
    input  logic            mem_stall,
    output logic            ex_busy,
    output logic            PCSrc,
    output logic [XLEN-1:0] PC_branch,
    output logic            ex_mem_valid,
    output logic            ex_mem_RegWrite,
    output logic            ex_mem_MemRead,
    output logic            ex_mem_MemWrite,
    output logic [XLEN-1:0] ex_mem_alu_result,
    output logic [XLEN-1:0] ex_mem_store_val,
    output logic [XLEN-1:0] ex_mem_link_val,
    output logic [4:0]      ex_mem_rd,
    output logic [1:0]      ex_mem_ResultSrc
);

    localparam int CW = SHW + 1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [XLEN-1:0] op_a_s;
    logic [XLEN-1:0] fwd_b_s;
    logic [XLEN-1:0] op_b_s;
    logic [SHW-1:0]  shamt_s;
    logic [XLEN-1:0] alu_res_s;
    logic [XLEN-1:0] link_val_s;
    logic [XLEN-1:0] ex_res_s;
    logic [XLEN-1:0] jalr_sum_s;
    logic            br_eq_s;
    logic            br_lt_s;
    logic            br_ltu_s;
    logic            br_taken_s;
    logic            md_start_s;
    logic [XLEN:0]   mul_sum_s;
    logic [XLEN:0]   rem_sh_s;
    logic [XLEN:0]   div_diff_s;
    logic [XLEN-1:0] md_res_s;

    // ------------------------------------------------------------------
    // Multiply/divide state
    // ------------------------------------------------------------------
    md_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // hi: product high half / partial remainder
    // lo: multiplier / dividend, shifting into product low half / quotient
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;   // multiplicand or divisor
    logic [1:0]      op_q, op_d;

    // ------------------------------------------------------------------
    // EX/MEM register
    // ------------------------------------------------------------------
    logic            valid_q, valid_d;
    logic            regwrite_q, regwrite_d;
    logic            memread_q, memread_d;
    logic            memwrite_q, memwrite_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] store_q, store_d;
    logic [XLEN-1:0] link_q, link_d;
    logic [4:0]      rd_q, rd_d;
    logic [1:0]      rsrc_q, rsrc_d;

    // Forwarding muxes and operand B select.
    always_comb begin
        case (ForwardAE)
            2'b10:   op_a_s = ex_mem_alu_result_in;
            2'b01:   op_a_s = wb_data_in;
            default: op_a_s = id_ex_rs1_val;
        endcase
        case (ForwardBE)
            2'b10:   fwd_b_s = ex_mem_alu_result_in;
            2'b01:   fwd_b_s = wb_data_in;
            default: fwd_b_s = id_ex_rs2_val;
        endcase
        if (id_ex_ALUSrc) begin
            op_b_s = id_ex_imm;
        end else begin
            op_b_s = fwd_b_s;
        end
    end

    assign shamt_s = op_b_s[SHW-1:0];

    // ALU proper; undefined control codes give zero.
    always_comb begin
        case (id_ex_ALUCtl)
            4'd0:    alu_res_s = op_a_s + op_b_s;
            4'd1:    alu_res_s = op_a_s - op_b_s;
            4'd2:    alu_res_s = op_a_s & op_b_s;
            4'd3:    alu_res_s = op_a_s | op_b_s;
            4'd4:    alu_res_s = op_a_s ^ op_b_s;
            4'd5:    alu_res_s = op_a_s << shamt_s;
            4'd6:    alu_res_s = op_a_s >> shamt_s;
            4'd7:    alu_res_s = $unsigned($signed(op_a_s) >>> shamt_s);
            4'd8:    alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
            4'd9:    alu_res_s = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
            default: alu_res_s = {XLEN{1'b0}};
        endcase
    end

    assign link_val_s = id_ex_pc + {{(XLEN-3){1'b0}}, 3'b100};

    // Link result overrides the ALU for JAL/JALR.
    always_comb begin
        if (id_ex_ResultSrc == 2'b10) begin
            ex_res_s = link_val_s;
        end else begin
            ex_res_s = alu_res_s;
        end
    end

    // Branch compare always uses the forwarded register values, never imm.
    assign br_eq_s  = (op_a_s == fwd_b_s);
    assign br_lt_s  = ($signed(op_a_s) < $signed(fwd_b_s));
    assign br_ltu_s = (op_a_s < fwd_b_s);

    // Branch condition decode by funct3.
    always_comb begin
        case (id_ex_BrCond)
            3'b000:  br_taken_s = br_eq_s;
            3'b001:  br_taken_s = ~br_eq_s;
            3'b100:  br_taken_s = br_lt_s;
            3'b101:  br_taken_s = ~br_lt_s;
            3'b110:  br_taken_s = br_ltu_s;
            3'b111:  br_taken_s = ~br_ltu_s;
            default: br_taken_s = 1'b0;
        endcase
    end

    // A redirect is suppressed under back-pressure so the instruction issuing
    // it is still in EX (and re-evaluated) when MEM frees up.
    assign PCSrc = id_ex_valid & ~mem_stall &
                   ((br_taken_s & id_ex_Branch) | id_ex_Jal | id_ex_Jalr);

    assign jalr_sum_s = op_a_s + id_ex_imm;

    // Redirect target; JALR clears bit 0 of the sum.
    always_comb begin
        if (id_ex_Jalr) begin
            PC_branch = jalr_sum_s & ~{{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            PC_branch = id_ex_pc + id_ex_imm;
        end
    end

    // ------------------------------------------------------------------
    // Multiply/divide unit
    // ------------------------------------------------------------------
    assign md_start_s = id_ex_valid & id_ex_MulDiv;

    // Reset gating keeps the front end free while reset is held.
    assign ex_busy = reset_n & md_start_s & (state_q != MD_DONE);

    // One shift-add step: add multiplicand on multiplier LSB, shift {hi,lo} right.
    assign mul_sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : {(XLEN+1){1'b0}});

    // One restoring-division step; the top bit of the difference is the borrow.
    // A zero divisor never borrows, which yields all-ones quotient and the
    // dividend as remainder without special casing.
    assign rem_sh_s   = {hi_q, lo_q[XLEN-1]};
    assign div_diff_s = rem_sh_s - {1'b0, dvs_q};

    // Result select by latched op.
    always_comb begin
        case (op_q)
            2'b00:   md_res_s = lo_q;
            2'b01:   md_res_s = hi_q;
            2'b10:   md_res_s = lo_q;
            2'b11:   md_res_s = hi_q;
            default: md_res_s = {XLEN{1'b0}};
        endcase
    end

    // Multiply/divide FSM next state and datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dvs_d   = dvs_q;
        op_d    = op_q;
        case (state_q)
            MD_IDLE: begin
                if (md_start_s) begin
                    state_d = MD_RUN;
                    cnt_d   = CW'(XLEN);
                    hi_d    = {XLEN{1'b0}};
                    lo_d    = op_a_s;
                    dvs_d   = fwd_b_s;
                    op_d    = id_ex_MdOp;
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_RUN: begin
                cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                if (op_q[1] == 1'b0) begin
                    hi_d = mul_sum_s[XLEN:1];
                    lo_d = {mul_sum_s[0], lo_q[XLEN-1:1]};
                end else if (div_diff_s[XLEN] == 1'b0) begin
                    hi_d = div_diff_s[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_d = rem_sh_s[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end
                if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
                    state_d = MD_DONE;
                end else begin
                    state_d = MD_RUN;
                end
            end
            MD_DONE: begin
                if (!mem_stall) begin
                    state_d = MD_IDLE;
                end else begin
                    state_d = MD_DONE;
                end
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    // EX/MEM update: hold on back-pressure, bubble while busy, else capture.
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        result_d   = result_q;
        store_d    = store_q;
        link_d     = link_q;
        rd_d       = rd_q;
        rsrc_d     = rsrc_q;
        if (mem_stall) begin
            valid_d = valid_q;
        end else if (ex_busy) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
        end else begin
            valid_d    = id_ex_valid;
            regwrite_d = id_ex_valid & id_ex_RegWrite;
            memread_d  = id_ex_valid & id_ex_MemRead;
            memwrite_d = id_ex_valid & id_ex_MemWrite;
            rsrc_d     = id_ex_ResultSrc & {2{id_ex_valid}};
            rd_d       = id_ex_rd_idx;
            store_d    = fwd_b_s;
            link_d     = link_val_s;
            if (state_q == MD_DONE) begin
                result_d = md_res_s;
            end else begin
                result_d = ex_res_s;
            end
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= MD_IDLE;
            cnt_q      <= {CW{1'b0}};
            hi_q       <= {XLEN{1'b0}};
            lo_q       <= {XLEN{1'b0}};
            dvs_q      <= {XLEN{1'b0}};
            op_q       <= 2'b00;
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            result_q   <= {XLEN{1'b0}};
            store_q    <= {XLEN{1'b0}};
            link_q     <= {XLEN{1'b0}};
            rd_q       <= 5'd0;
            rsrc_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dvs_q      <= dvs_d;
            op_q       <= op_d;
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            result_q   <= result_d;
            store_q    <= store_d;
            link_q     <= link_d;
            rd_q       <= rd_d;
            rsrc_q     <= rsrc_d;
        end
    end

    assign ex_mem_valid      = valid_q;
    assign ex_mem_RegWrite   = regwrite_q;
    assign ex_mem_MemRead    = memread_q;
    assign ex_mem_MemWrite   = memwrite_q;
    assign ex_mem_alu_result = result_q;
    assign ex_mem_store_val  = store_q;
    assign ex_mem_link_val   = link_q;
    assign ex_mem_rd         = rd_q;
    assign ex_mem_ResultSrc  = rsrc_q;

endmodule

// File: tb/tb_ex_stage_md.sv
// Testbench for ex_stage_md (XLEN = 32): table-driven single-cycle vectors
// followed by hand-written multiply/divide, back-pressure and reset sequences.
module tb_ex_stage_md;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        id_ex_valid;
    logic [31:0] id_ex_pc, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm;
    logic [4:0]  id_ex_rd_idx;
    logic        id_ex_RegWrite, id_ex_MemRead, id_ex_MemWrite, id_ex_ALUSrc;
    logic [1:0]  id_ex_ResultSrc;
    logic [3:0]  id_ex_ALUCtl;
    logic        id_ex_MulDiv;
    logic [1:0]  id_ex_MdOp;
    logic        id_ex_Branch, id_ex_Jal, id_ex_Jalr;
    logic [2:0]  id_ex_BrCond;
    logic [31:0] ex_mem_alu_result_in, wb_data_in;
    logic        mem_stall;
    logic        ex_busy, PCSrc;
    logic [31:0] PC_branch;
    logic        ex_mem_valid, ex_mem_RegWrite, ex_mem_MemRead, ex_mem_MemWrite;
    logic [31:0] ex_mem_alu_result, ex_mem_store_val, ex_mem_link_val;
    logic [4:0]  ex_mem_rd;
    logic [1:0]  ex_mem_ResultSrc;

    int n_cmp  = 0;
    int n_fail = 0;

    ex_stage_md #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc),
        .id_ex_rs1_val(id_ex_rs1_val), .id_ex_rs2_val(id_ex_rs2_val),
        .id_ex_imm(id_ex_imm), .id_ex_rd_idx(id_ex_rd_idx),
        .id_ex_RegWrite(id_ex_RegWrite), .id_ex_MemRead(id_ex_MemRead),
        .id_ex_MemWrite(id_ex_MemWrite), .id_ex_ALUSrc(id_ex_ALUSrc),
        .id_ex_ResultSrc(id_ex_ResultSrc), .id_ex_ALUCtl(id_ex_ALUCtl),
        .id_ex_MulDiv(id_ex_MulDiv), .id_ex_MdOp(id_ex_MdOp),
        .id_ex_Branch(id_ex_Branch), .id_ex_Jal(id_ex_Jal), .id_ex_Jalr(id_ex_Jalr),
        .id_ex_BrCond(id_ex_BrCond),
        .ex_mem_alu_result_in(ex_mem_alu_result_in), .wb_data_in(wb_data_in),
        .mem_stall(mem_stall), .ex_busy(ex_busy),
        .PCSrc(PCSrc), .PC_branch(PC_branch),
        .ex_mem_valid(ex_mem_valid), .ex_mem_RegWrite(ex_mem_RegWrite),
        .ex_mem_MemRead(ex_mem_MemRead), .ex_mem_MemWrite(ex_mem_MemWrite),
        .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_store_val(ex_mem_store_val),
        .ex_mem_link_val(ex_mem_link_val), .ex_mem_rd(ex_mem_rd),
        .ex_mem_ResultSrc(ex_mem_ResultSrc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [1:0]  fa, fb;
        logic [31:0] fwd_mem, fwd_wb, pc, rs1, rs2, imm;
        logic        alusrc;
        logic [3:0]  ctl;
        logic [1:0]  rsrc;
        logic        br, jal, jalr;
        logic [2:0]  cond;
        logic        stall;
        logic        e_pcsrc;
        logic        c_pcb;
        logic [31:0] e_pcb;
        logic        e_valid;
        logic [31:0] e_res, e_store;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t alu_v(input logic [1:0] fa, input logic [1:0] fb,
                                   input logic [31:0] mem, input logic [31:0] wb,
                                   input logic [31:0] rs1, input logic [31:0] rs2,
                                   input logic [31:0] imm, input logic alusrc,
                                   input logic [3:0] ctl, input logic [31:0] res,
                                   input logic [31:0] store);
        vec_t t;
        t = '0;
        t.valid = 1'b1; t.fa = fa; t.fb = fb; t.fwd_mem = mem; t.fwd_wb = wb;
        t.rs1 = rs1; t.rs2 = rs2; t.imm = imm; t.alusrc = alusrc; t.ctl = ctl;
        t.e_valid = 1'b1; t.e_res = res; t.e_store = store;
        return t;
    endfunction

    function automatic vec_t cf_v(input logic valid, input logic [31:0] pc,
                                  input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [31:0] imm, input logic alusrc,
                                  input logic [1:0] rsrc, input logic br,
                                  input logic jal, input logic jalr,
                                  input logic [2:0] cond, input logic stall,
                                  input logic e_pcsrc, input logic [31:0] e_pcb,
                                  input logic e_valid, input logic [31:0] e_res,
                                  input logic [31:0] e_store);
        vec_t t;
        t = '0;
        t.valid = valid; t.pc = pc; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm;
        t.alusrc = alusrc; t.rsrc = rsrc; t.br = br; t.jal = jal; t.jalr = jalr;
        t.cond = cond; t.stall = stall; t.e_pcsrc = e_pcsrc; t.c_pcb = 1'b1;
        t.e_pcb = e_pcb; t.e_valid = e_valid; t.e_res = e_res; t.e_store = e_store;
        return t;
    endfunction

    task automatic clear_inputs();
        ForwardAE = 2'b00; ForwardBE = 2'b00; id_ex_valid = 1'b0;
        id_ex_pc = 32'h0; id_ex_rs1_val = 32'h0; id_ex_rs2_val = 32'h0; id_ex_imm = 32'h0;
        id_ex_rd_idx = 5'd0; id_ex_RegWrite = 1'b0; id_ex_MemRead = 1'b0;
        id_ex_MemWrite = 1'b0; id_ex_ALUSrc = 1'b0; id_ex_ResultSrc = 2'b00;
        id_ex_ALUCtl = 4'd0; id_ex_MulDiv = 1'b0; id_ex_MdOp = 2'b00;
        id_ex_Branch = 1'b0; id_ex_Jal = 1'b0; id_ex_Jalr = 1'b0; id_ex_BrCond = 3'b000;
        ex_mem_alu_result_in = 32'h0; wb_data_in = 32'h0; mem_stall = 1'b0;
    endtask

    task automatic apply(input vec_t t);
        ForwardAE = t.fa; ForwardBE = t.fb; id_ex_valid = t.valid;
        ex_mem_alu_result_in = t.fwd_mem; wb_data_in = t.fwd_wb;
        id_ex_pc = t.pc; id_ex_rs1_val = t.rs1; id_ex_rs2_val = t.rs2; id_ex_imm = t.imm;
        id_ex_ALUSrc = t.alusrc; id_ex_ALUCtl = t.ctl; id_ex_ResultSrc = t.rsrc;
        id_ex_Branch = t.br; id_ex_Jal = t.jal; id_ex_Jalr = t.jalr; id_ex_BrCond = t.cond;
        mem_stall = t.stall; id_ex_RegWrite = 1'b1; id_ex_MemRead = 1'b0;
        id_ex_MemWrite = 1'b0; id_ex_MulDiv = 1'b0; id_ex_rd_idx = 5'd3;
    endtask

    // Issue one multiply/divide op and follow it to EX/MEM. Leaves the op in
    // ID/EX so a following call is back-to-back.
    task automatic md_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int stall_n, input string nm);
        int busy;
        busy = 0;
        @(negedge clk);
        clear_inputs();
        id_ex_valid = 1'b1; id_ex_MulDiv = 1'b1; id_ex_MdOp = op;
        id_ex_rs1_val = a; id_ex_rs2_val = b; id_ex_rd_idx = 5'd9; id_ex_RegWrite = 1'b1;
        #1;
        while (ex_busy === 1'b1 && busy < 100) begin
            busy++;
            @(negedge clk);
            if (busy == 3) begin
                // forwarding sources change mid-run; operands are already latched
                ForwardAE = 2'b10; ForwardBE = 2'b01;
                ex_mem_alu_result_in = 32'h1234_5678; wb_data_in = 32'h0;
            end
            #1;
        end
        chk({nm, "_busy_cycles"}, busy, 32'd33);
        chk({nm, "_bubble_valid"}, {31'b0, ex_mem_valid}, 32'd0);
        if (stall_n > 0) begin
            mem_stall = 1'b1;
            for (int i = 0; i < stall_n; i++) begin
                @(posedge clk); #1;
                chk({nm, "_stall_valid"}, {31'b0, ex_mem_valid}, 32'd0);
                chk({nm, "_stall_busy"}, {31'b0, ex_busy}, 32'd0);
            end
            @(negedge clk);
            mem_stall = 1'b0;
        end
        @(posedge clk); #1;
        chk({nm, "_result"}, ex_mem_alu_result, exp);
        chk({nm, "_valid"}, {31'b0, ex_mem_valid}, 32'd1);
        chk({nm, "_rd"}, {27'b0, ex_mem_rd}, 32'd9);
        ForwardAE = 2'b00; ForwardBE = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // ALU vectors: fa, fb, mem, wb, rs1, rs2, imm, alusrc, ctl, result, store
        vecs[0]  = alu_v(2'b10, 2'b00, 32'h5, 32'h0, 32'h0, 32'h7, 32'h0, 1'b0, 4'd0, 32'hC, 32'h7);
        vecs[1]  = alu_v(2'b00, 2'b00, 32'h0, 32'h0, 32'h5, 32'h7, 32'h0, 1'b0, 4'd1, 32'hFFFF_FFFE, 32'h7);
        vecs[2]  = alu_v(2'b00, 2'b00, 32'h0, 32'h0, 32'hF0F0, 32'hFF00, 32'h0, 1'b0, 4'd2, 32'hF000, 32'hFF00);
        vecs[3]  = alu_v(2'b00, 2'b00, 32'h0, 32'h0, 32'hF0F0, 32'hFF00, 32'h0, 1'b0, 4'd3, 32'hFFF0, 32'hFF00);
        vecs[4]  = alu_v(2'b00, 2'b00, 32'h0, 32'h0, 32'hF0F0, 32'hFF00, 32'h0, 1'b0, 4'd4, 32'h0FF0, 32'hFF00);
        vecs[5]  = alu_v(2'b00, 2'b00, 32'h0, 32'h0, 32'h1, 32'hDEAD, 32'h24, 1'b1, 4'd5, 32'h10, 32'hDEAD);
        vecs[6]  = alu_v(2'b00, 2'b00, 32'h0, 32'h0, 32'h8000_0000, 32'h1F, 32'h0, 1'b0, 4'd6, 32'h1, 32'h1F);
        vecs[7]  = alu_v(2'b00, 2'b00, 32'h0, 32'h0, 32'h8000_0000, 32'h4, 32'h0, 1'b0, 4'd7, 32'hF800_0000, 32'h4);
        vecs[8]  = alu_v(2'b00, 2'b00, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 4'd8, 32'h1, 32'h1);
        vecs[9]  = alu_v(2'b00, 2'b00, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 4'd9, 32'h0, 32'h1);
        vecs[10] = alu_v(2'b00, 2'b00, 32'h0, 32'h0, 32'h5, 32'h7, 32'h0, 1'b0, 4'd10, 32'h0, 32'h7);
        vecs[11] = alu_v(2'b00, 2'b01, 32'h0, 32'h3, 32'h4, 32'h99, 32'h0, 1'b0, 4'd0, 32'h7, 32'h3);
        vecs[12] = alu_v(2'b01, 2'b10, 32'h20, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 32'h30, 32'h20);
        vecs[13] = alu_v(2'b11, 2'b00, 32'h1, 32'h2, 32'h9, 32'h1, 32'h0, 1'b0, 4'd0, 32'hA, 32'h1);
        // control flow: valid, pc, rs1, rs2, imm, alusrc, rsrc, br, jal, jalr, cond, stall,
        //               pcsrc, pc_branch, ex_mem_valid, result, store
        vecs[14] = cf_v(1'b1, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1, 32'h120, 1'b1, 32'h0, 32'h1);
        vecs[15] = cf_v(1'b1, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 32'h120, 1'b1, 32'h0, 32'h1);
        vecs[16] = cf_v(1'b1, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 32'h120, 1'b1, 32'h0, 32'h1);
        vecs[17] = cf_v(1'b1, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 32'h120, 1'b1, 32'h0, 32'h1);
        vecs[18] = cf_v(1'b1, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1, 32'h120, 1'b1, 32'h0, 32'h1);
        vecs[19] = cf_v(1'b1, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 32'h120, 1'b1, 32'h0, 32'h1);
        vecs[20] = cf_v(1'b1, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 32'h120, 1'b1, 32'h0, 32'h1);
        vecs[21] = cf_v(1'b1, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 32'h120, 1'b1, 32'h0, 32'h1);
        vecs[22] = cf_v(1'b1, 32'h100, 32'h55, 32'h55, 32'h20, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 32'h120, 1'b1, 32'hAA, 32'h55);
        vecs[23] = cf_v(1'b1, 32'h200, 32'h1003, 32'h0, 32'h4, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 32'h1006, 1'b1, 32'h204, 32'h0);
        vecs[24] = cf_v(1'b1, 32'h200, 32'h0, 32'h0, 32'h800, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 32'hA00, 1'b1, 32'h204, 32'h0);
        vecs[25] = cf_v(1'b0, 32'h200, 32'h1003, 32'h0, 32'h4, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h1006, 1'b0, 32'h204, 32'h0);
        vecs[26] = cf_v(1'b1, 32'h200, 32'h1003, 32'h0, 32'h4, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 32'h1006, 1'b0, 32'h204, 32'h0);

        // reset state; redirect stays combinational, busy is forced low
        clear_inputs();
        reset_n = 1'b0;
        id_ex_valid = 1'b1; id_ex_Jal = 1'b1; id_ex_MulDiv = 1'b1;
        id_ex_pc = 32'h40; id_ex_imm = 32'h10;
        #2;
        chk("rst_pcsrc", {31'b0, PCSrc}, 32'd1);
        chk("rst_pc_branch", PC_branch, 32'h50);
        chk("rst_busy", {31'b0, ex_busy}, 32'd0);
        chk("rst_valid", {31'b0, ex_mem_valid}, 32'd0);
        chk("rst_result", ex_mem_alu_result, 32'h0);
        clear_inputs();
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            chk($sformatf("v%0d_pcsrc", i), {31'b0, PCSrc}, {31'b0, vecs[i].e_pcsrc});
            if (vecs[i].c_pcb) begin
                chk($sformatf("v%0d_pc_branch", i), PC_branch, vecs[i].e_pcb);
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), {31'b0, ex_mem_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d_regwrite", i), {31'b0, ex_mem_RegWrite}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d_result", i), ex_mem_alu_result, vecs[i].e_res);
            chk($sformatf("v%0d_store", i), ex_mem_store_val, vecs[i].e_store);
        end

        // multiply/divide, issued back-to-back
        md_op(2'b00, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 0, "mul");
        md_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu");
        md_op(2'b10, 32'd100, 32'd7, 32'd14, 3, "divu_stall");
        md_op(2'b11, 32'd100, 32'd7, 32'd2, 0, "remu");
        md_op(2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, "divu_zero");
        md_op(2'b11, 32'd5, 32'd0, 32'd5, 0, "remu_zero");

        // reset in the middle of a running multiply
        @(negedge clk);
        clear_inputs();
        id_ex_valid = 1'b1; id_ex_MulDiv = 1'b1; id_ex_MdOp = 2'b00;
        id_ex_rs1_val = 32'd7; id_ex_rs2_val = 32'd9; id_ex_RegWrite = 1'b1; id_ex_rd_idx = 5'd4;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, ex_busy}, 32'd0);
        chk("midrst_valid", {31'b0, ex_mem_valid}, 32'd0);
        chk("midrst_ctl", {28'b0, ex_mem_RegWrite, ex_mem_MemRead, ex_mem_MemWrite, 1'b0}, 32'd0);
        chk("midrst_result", ex_mem_alu_result, 32'h0);
        chk("midrst_store", ex_mem_store_val, 32'h0);
        chk("midrst_link", ex_mem_link_val, 32'h0);
        chk("midrst_rd_rsrc", {25'b0, ex_mem_rd, ex_mem_ResultSrc}, 32'h0);
        id_ex_valid = 1'b0; id_ex_MulDiv = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        md_op(2'b00, 32'd3, 32'd4, 32'd12, 0, "mul_after_rst");

        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage_md.md
# ex_stage_md

Parametrised execute stage for the five-stage pipeline: XLEN-wide ALU with forwarding, full RISC-V conditional-branch compare, and an iterative unsigned multiply/divide unit that stalls the front end while it runs. Sits between the ID/EX and EX/MEM pipeline registers, owns the EX/MEM register, and drives the PC redirect back to IF. Supports downstream back-pressure (`mem_stall`) and bubble insertion.

## Interface
- `XLEN`, 32: datapath width, ≥8, power of two.
- `SHW`, $clog2(XLEN): shift-amount width, derived, not overridden.

Ports:
- `clk`  in  1: clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `ForwardAE`, `ForwardBE`  in  2 each: operand select. 10 = `ex_mem_alu_result_in`, 01 = `wb_data_in`, else register value.
- `id_ex_valid`  in  1: ID/EX holds a real instruction.
- `id_ex_pc`, `id_ex_rs1_val`, `id_ex_rs2_val`, `id_ex_imm`  in  XLEN each: PC, register operands, and immediate.
- `id_ex_rd_idx`  in  5: destination register.
- `id_ex_RegWrite`, `id_ex_MemRead`, `id_ex_MemWrite`, `id_ex_ALUSrc`  in  1 each: standard controls.
- `id_ex_ResultSrc`  in  2: 10 = link (PC+4) result.
- `id_ex_ALUCtl`  in  4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU. Other codes yield 0.
- `id_ex_MulDiv`  in  1: instruction uses the multiply/divide unit.
- `id_ex_MdOp`  in  2: 00 MUL (low half), 01 MULHU, 10 DIVU, 11 REMU.
- `id_ex_Branch`, `id_ex_Jal`, `id_ex_Jalr`  in  1 each: control-flow type.
- `id_ex_BrCond`  in  3: funct3. 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. Other codes are never taken.
- `ex_mem_alu_result_in`, `wb_data_in`  in  XLEN each: forwarding sources.
- `mem_stall`  in  1: MEM stage cannot accept; EX/MEM holds.
- `ex_busy`  out  1: hold IF, ID, and ID/EX this cycle.
- `PCSrc`  out  1: redirect the PC. `PC_branch`  out  XLEN: redirect target.
- `ex_mem_valid`, `ex_mem_RegWrite`, `ex_mem_MemRead`, `ex_mem_MemWrite`  out  1 each (registered).
- `ex_mem_alu_result`, `ex_mem_store_val`, `ex_mem_link_val`  out  XLEN each (registered).
- `ex_mem_rd`  out  5; `ex_mem_ResultSrc`  out  2 (registered).

## Operation
- Operand A is the forwarded rs1 value.
- Operand B is `id_ex_imm` when `ALUSrc` = 1, otherwise the forwarded rs2 value.
- `store_val` is always the forwarded rs2 value.
- Shifts use only B[SHW-1:0]. SLT is a signed compare, SLTU is unsigned; both produce 0 or 1, zero-extended.
- Branch compares use the forwarded rs1 and rs2 values, never B.
- `PCSrc` = `id_ex_valid` & ~`mem_stall` & (taken & `Branch` | `Jal` | `Jalr`).
- `PC_branch` = `Jalr` ? {(A+imm)[XLEN-1:1], 0} : `pc` + `imm`, computed modulo 2^XLEN.
- `link_val` = `pc` + 4. The EX result is `link_val` when `ResultSrc` = 10.
- Multiply/divide FSM has states IDLE, RUN, DONE:
  - IDLE → RUN when `id_ex_valid` & `MulDiv`. Latches both forwarded operands and `MdOp`, and loads the counter with XLEN.
  - RUN: one iteration per cycle; shift-add for multiply, restoring division for divide. Counter decrements; at 1, go to DONE.
  - DONE → IDLE when ~`mem_stall`, otherwise stay in DONE holding the result.
- Division by zero: DIVU returns all ones; REMU returns the dividend.
- MULHU returns product[2·XLEN-1:XLEN].
- `ex_busy` = `id_ex_valid` & `MulDiv` & (state ≠ DONE).
- EX/MEM update priority:
  - `mem_stall`: hold all fields.
  - else `ex_busy`: bubble. `valid`, `RegWrite`, `MemRead`, and `MemWrite` go to 0; other fields are don't-care.
  - else capture. Capture uses the MD result when the FSM is in DONE, the ALU/link result otherwise, and sets `ex_mem_valid` = `id_ex_valid`.
  - With `id_ex_valid` = 0, all control bits are captured as 0.

## Timing
- Reset (`reset_n` low, asynchronous): FSM goes to IDLE, counter to 0, all `ex_mem_*` outputs to 0.
- While reset is active, `ex_busy` = 0 and `PCSrc` reflects the inputs combinationally.
- Reset asserted mid-RUN abandons the operation; no partial result is ever written.
- ALU, branch, and jump ops: result appears in EX/MEM at the next rising edge. `PCSrc` and `PC_branch` are combinational in the same cycle.
- Multiply/divide, with the op entering ID/EX on cycle 0:
  - `ex_busy` = 1 on cycles 0 through XLEN.
  - DONE on cycle XLEN+1, with `ex_busy` = 0.
  - Result is in EX/MEM after the edge ending cycle XLEN+1. Total latency is XLEN+2 cycles.
- The forwarding inputs may change during RUN without affecting the result, because operands are latched at IDLE.
- Back-to-back multiply/divide ops: the second op enters IDLE on the cycle after DONE. There are no dead cycles beyond that.

## Test plan
- Forwarded ADD: ForwardAE=10, `ex_mem_alu_result_in`=5, rs2=7, ALUCtl=0 → `ex_mem_alu_result`=12, `ex_mem_valid`=1 after one edge.
- Signed vs unsigned branch: rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20.
  - BLT → `PCSrc`=1, `PC_branch`=0x120.
  - BLTU → `PCSrc`=0.
  - BEQ with the same operands under `mem_stall`=1 → `PCSrc`=0.
- Multiply: MUL 0xFFFF×0x10001 → 0xFFFFFFFF, with `ex_busy` high for exactly 33 cycles and the result captured on cycle 34. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- Divide: DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
- Stall/reset: hold `mem_stall`=1 for 3 cycles in DONE → EX/MEM unchanged and result delivered after release. Drop `reset_n` mid-RUN → `ex_busy`=0 and all `ex_mem_*`=0; a following MUL 3×4 returns 12.
- JALR: rs1=0x1003, imm=4, pc=0x200, ResultSrc=10 → `PC_branch`=0x1006, `ex_mem_alu_result`=0x204.
